dbp_dbx_dec: RTL

- Inverse of the DBP/DBX front end in the BPC compressor. Lives in the BPC decompressor, downstream of the sequence decoder.
- Takes one fully decoded block (a base word plus the DBX bit-planes) per handshake.
- Rebuilds the DBP planes, then the deltas, then the original words.
- Emits the words one per cycle on a valid/ready stream.

---
 rtl/dbp_dbx_dec.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/dbp_dbx_dec.sv
// dbp_dbx_dec: rebuilds DBP planes, deltas and words from one decoded BPC block and emits
// one word per cycle. Define DBP_DBX_DEC_PREDECODE_EN to add a one-entry predecoded input stage.
module dbp_dbx_dec #(
   parameter int DATA_W     = 8,
   parameter int BLOCK_SIZE = 8
) (
   input  logic                                      clk_i,
   input  logic                                      rst_i,
   input  logic [DATA_W-1:0]                         base_i,
   input  logic [(DATA_W+1)*(BLOCK_SIZE-1)-1:0]      dbx_i,
   input  logic [$clog2(BLOCK_SIZE+1)-1:0]           num_words_i,
   input  logic                                      last_i,
   input  logic                                      vld_i,
   output logic                                      rdy_o,
   output logic [DATA_W-1:0]                         data_o,
   output logic                                      last_o,
   output logic                                      vld_o,
   input  logic                                      rdy_i,
   output logic                                      idle_o
);
   localparam int NDELTA = BLOCK_SIZE - 1;
   localparam int DBX_W  = (DATA_W + 1) * NDELTA;
   localparam int NW     = $clog2(BLOCK_SIZE + 1);

   // Words are summed mod 2^DATA_W, so each delta keeps only its low DATA_W bits.
   typedef logic [NDELTA-1:0][DATA_W-1:0] dlt_t;
   typedef enum logic {IDLE, EMIT} state_t;

   // Undo the DBX xor from the top plane down, then transpose planes into per-delta words.
   function automatic dlt_t decode(input logic [DBX_W-1:0] dbx);
      logic [NDELTA-1:0] plane;
      dlt_t              d;
      plane = '0;
      d     = '0;
      for (int j = DATA_W; j >= 0; j--) begin
         plane = plane ^ dbx[j*NDELTA +: NDELTA];
         if (j < DATA_W) begin
            for (int k = 0; k < NDELTA; k++) d[k][j] = plane[k];
         end
      end
      return d;
   endfunction

   logic              src_vld;
   logic [DATA_W-1:0] src_base;
   dlt_t              src_dlt;
   logic [NW-1:0]     src_num;
   logic              src_last;
   logic              fsm_rdy;
   logic              fsm_load;

   state_t            state_q, state_d;
   logic [NW-1:0]     cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   dlt_t              held_dlt;
   logic [NW-1:0]     held_num;
   logic              held_last;
   logic              final_word;
   logic [DATA_W-1:0] step_dlt;

   assign fsm_load = src_vld && fsm_rdy;

`ifdef DBP_DBX_DEC_PREDECODE_EN
   logic              stage_full;
   logic [DATA_W-1:0] stage_base;
   dlt_t              stage_dlt;
   logic [NW-1:0]     stage_num;
   logic              stage_last;

   // The stage may refill in the same cycle it hands its block to the FSM.
   assign rdy_o = !stage_full || fsm_load;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         stage_full <= 1'b0;
         stage_base <= '0;
         stage_dlt  <= '0;
         stage_num  <= '0;
         stage_last <= 1'b0;
      end else if (vld_i && rdy_o) begin
         stage_full <= 1'b1;
         stage_base <= base_i;
         stage_dlt  <= decode(dbx_i);
         stage_num  <= num_words_i;
         stage_last <= last_i;
      end else if (fsm_load) begin
         stage_full <= 1'b0;
      end
   end

   assign src_vld  = stage_full;
   assign src_base = stage_base;
   assign src_dlt  = stage_dlt;
   assign src_num  = stage_num;
   assign src_last = stage_last;
   assign idle_o   = (state_q == IDLE) && !stage_full;
`else
   assign rdy_o    = fsm_rdy;
   assign src_vld  = vld_i;
   assign src_base = base_i;
   assign src_dlt  = decode(dbx_i);
   assign src_num  = num_words_i;
   assign src_last = last_i;
   assign idle_o   = (state_q == IDLE);
`endif

   assign final_word = (cnt_q == held_num - NW'(1));
   assign data_o     = acc_q;

   always_comb begin
      step_dlt = '0;
      for (int k = 0; k < NDELTA; k++) begin
         if (cnt_q == NW'(k)) step_dlt = held_dlt[k];
      end
   end

   // NOTE: every output of this block is given a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      acc_d   = acc_q;
      vld_o   = 1'b0;
      last_o  = 1'b0;
      fsm_rdy = 1'b0;
      case (state_q)
         IDLE: begin
            fsm_rdy = 1'b1;
            if (src_vld) begin
               state_d = EMIT;
               cnt_d   = '0;
               acc_d   = src_base;
            end
         end
         EMIT: begin
            vld_o   = 1'b1;
            last_o  = held_last && final_word;
            fsm_rdy = rdy_i && final_word;
            if (rdy_i) begin
               if (!final_word) begin
                  cnt_d = cnt_q + NW'(1);
                  acc_d = acc_q + step_dlt;
               end else if (src_vld) begin
                  cnt_d = '0;
                  acc_d = src_base;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   // NOTE: the held block is cleared on reset too, so a dropped block leaves no stale deltas behind.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         acc_q     <= '0;
         held_dlt  <= '0;
         held_num  <= '0;
         held_last <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         acc_q   <= acc_d;
         if (fsm_load) begin
            held_dlt  <= src_dlt;
            held_num  <= src_num;
            held_last <= src_last;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_i && vld_i && rdy_o)
         assert (num_words_i != '0 && num_words_i <= NW'(BLOCK_SIZE));
   end
endmodule
